// File: rtl/dm_subword_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dm_subword_ctrl                                        |
// | Description : Word-organised data memory with byte/half/word access, |
// |               sign/zero-extended loads, alignment and range errors,  |
// |               fixed access latency and a post-reset clear sweep.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dm_subword_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The latency counter only ever holds values up to LATENCY-2.
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0]       mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [LAT_W-1:0]  lat_cnt;

  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_unsigned;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_unsigned;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-3:0] word_addr;
  logic [CNT_W-1:0]  idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              acc_err;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [3:0]        lane_mask;
  logic [31:0]       wdata_shifted;
  logic [31:0]       merged;

  assign accept     = (state == ST_IDLE) && req_valid;
  // With LATENCY = 1 the access happens on the acceptance edge itself.
  assign enter_resp = ((state == ST_BUSY) && (lat_cnt == '0)) ||
                      (accept && (LATENCY == 1));

  // Access fields: live inputs on the acceptance edge, captured copy afterwards.
  always_comb begin
    acc_we       = cap_we;
    acc_size     = cap_size;
    acc_unsigned = cap_unsigned;
    acc_addr     = cap_addr;
    acc_wdata    = cap_wdata;
    if (state == ST_IDLE) begin
      acc_we       = req_we;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr;
      acc_wdata    = req_wdata;
    end
  end

  assign word_addr    = acc_addr[ADDR_W-1:2];
  assign idx          = word_addr[CNT_W-1:0];
  assign lane         = acc_addr[1:0];
  assign out_of_range = 32'(word_addr) >= 32'(DEPTH);
  assign acc_err      = (acc_size == 2'b11) ||
                        ((acc_size == 2'b01) && acc_addr[0]) ||
                        ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00)) ||
                        out_of_range;

  assign rd_word       = mem[idx];
  assign shifted       = rd_word >> {lane, 3'b000};
  assign wdata_shifted = acc_wdata << {lane, 3'b000};

  // Lane extraction with sign or zero extension for loads.
  always_comb begin
    load_data = rd_word;
    case (acc_size)
      2'b00:   load_data = acc_unsigned ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = acc_unsigned ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Byte-lane merge for the store read-modify-write.
  always_comb begin
    lane_mask = 4'b1111;
    case (acc_size)
      2'b00:   lane_mask = 4'b0001 << lane;
      2'b01:   lane_mask = 4'b0011 << lane;
      default: lane_mask = 4'b1111;
    endcase
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (lane_mask[b]) merged[8*b +: 8] = wdata_shifted[8*b +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_INIT: if (cnt == LAST_IDX) state_next = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      end
      ST_BUSY: if (lat_cnt == '0) state_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Sweep counter, request capture, latency count and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      init_done    <= 1'b0;
      lat_cnt      <= '0;
      cap_we       <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST_IDX) init_done <= 1'b1;
      end
      if (accept) begin
        cap_we       <= req_we;
        cap_size     <= req_size;
        cap_unsigned <= req_unsigned;
        cap_addr     <= req_addr;
        cap_wdata    <= req_wdata;
        lat_cnt      <= LAT_LOAD;
      end else if ((state == ST_BUSY) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || acc_we) ? 32'd0 : load_data;
      end
    end
  end

  // RAM: clear sweep during INIT, otherwise merged store commit entering RESP.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= 32'd0;
    end else if (enter_resp && acc_we && !acc_err) begin
      mem[idx] <= merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_subword_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dm_subword_ctrl                                     |
// | Description : Directed self-checking bench for dm_subword_ctrl       |
// |               (DEPTH = 16, LATENCY = 3).                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dm_subword_ctrl;

  localparam int ADDR_W  = 14;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              init_done;

  int total = 0;
  int bad   = 0;

  dm_subword_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Release reset and count cycles until the sweep finishes; req_valid is
  // optionally held high to show requests during INIT are ignored.
  task automatic run_init(input string tag, input logic poke);
    int n = 0;
    int ready_seen = 0;
    int resp_seen = 0;
    reset = 1'b1;
    req_valid = poke;
    req_we = 1'b0; req_size = 2'b10; req_addr = 14'h0010;
    while (!init_done && n < 100) begin
      if (req_ready)  ready_seen++;
      if (resp_valid) resp_seen++;
      if (n == DEPTH - 2) req_valid = 1'b0;
      tick();
      n++;
    end
    req_valid = 1'b0;
    chk({tag, "_cycles"}, 32'(n), 32'(DEPTH));
    chk({tag, "_ready_low"}, 32'(ready_seen), 32'd0);
    chk({tag, "_no_resp"}, 32'(resp_seen), 32'd0);
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  // One request; inputs are scrambled after acceptance so the response must
  // come from the captured values.
  task automatic req(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [ADDR_W-1:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err);
    int n = 0;
    int ready_hi = 0;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = addr ^ 14'h0004; req_wdata = ~wdata;
    while (!resp_valid && n < 20) begin
      if (req_ready) ready_hi++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LATENCY - 1));
    chk({tag, "_busy_ready"}, 32'(ready_hi), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    tick();
    chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err",   {31'd0, resp_err}, 32'd0);
    chk("rst_init",  {31'd0, init_done}, 32'd0);

    run_init("init1", 1'b1);
    req("lw_top",  1'b0, 2'b10, 1'b0, 14'h003C, 32'h0, 32'h00000000, 1'b0);

    // Word store / load
    req("sw10",    1'b1, 2'b10, 1'b0, 14'h0010, 32'h12345678, 32'h0, 1'b0);
    req("lw10",    1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, 32'h12345678, 1'b0);

    // Subword store / load
    req("sb13",    1'b1, 2'b00, 1'b0, 14'h0013, 32'hCDEF01AB, 32'h0, 1'b0);
    req("lw10b",   1'b0, 2'b10, 1'b1, 14'h0010, 32'h0, 32'hAB345678, 1'b0);
    req("lb13",    1'b0, 2'b00, 1'b0, 14'h0013, 32'h0, 32'hFFFFFFAB, 1'b0);
    req("lbu13",   1'b0, 2'b00, 1'b1, 14'h0013, 32'h0, 32'h000000AB, 1'b0);
    req("sh10",    1'b1, 2'b01, 1'b0, 14'h0010, 32'h55558001, 32'h0, 1'b0);
    req("lh10",    1'b0, 2'b01, 1'b0, 14'h0010, 32'h0, 32'hFFFF8001, 1'b0);
    req("lhu10",   1'b0, 2'b01, 1'b1, 14'h0010, 32'h0, 32'h00008001, 1'b0);
    req("lh12",    1'b0, 2'b01, 1'b0, 14'h0012, 32'h0, 32'hFFFFAB34, 1'b0);
    req("lhu12",   1'b0, 2'b01, 1'b1, 14'h0012, 32'h0, 32'h0000AB34, 1'b0);
    req("lb11",    1'b0, 2'b00, 1'b0, 14'h0011, 32'h0, 32'hFFFFFF80, 1'b0);
    req("lbu10",   1'b0, 2'b00, 1'b1, 14'h0010, 32'h0, 32'h00000001, 1'b0);
    req("lw10c",   1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, 32'hAB348001, 1'b0);

    // Errors
    req("lh11",    1'b0, 2'b01, 1'b0, 14'h0011, 32'h0, 32'h0, 1'b1);
    req("sw12",    1'b1, 2'b10, 1'b0, 14'h0012, 32'hFFFFFFFF, 32'h0, 1'b1);
    req("lw10d",   1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, 32'hAB348001, 1'b0);
    req("size11",  1'b0, 2'b11, 1'b0, 14'h0010, 32'h0, 32'h0, 1'b1);
    req("lw_oor",  1'b0, 2'b10, 1'b0, 14'(DEPTH * 4), 32'h0, 32'h0, 1'b1);
    req("sb_oor",  1'b1, 2'b00, 1'b0, 14'h0043, 32'h000000EE, 32'h0, 1'b1);
    req("sb3f",    1'b1, 2'b00, 1'b0, 14'h003F, 32'h0000007F, 32'h0, 1'b0);
    req("lb3f",    1'b0, 2'b00, 1'b0, 14'h003F, 32'h0, 32'h0000007F, 1'b0);
    req("lw00",    1'b0, 2'b10, 1'b0, 14'h0000, 32'h0, 32'h00000000, 1'b0);

    // Reset during BUSY of a store
    chk("mid_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 14'h0020; req_wdata = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    chk("mid_busy", {31'd0, req_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_init",  {31'd0, init_done}, 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (resp_valid) pulses++;
      end
      chk("mid_no_pulse", 32'(pulses), 32'd0);
    end
    run_init("init2", 1'b0);
    req("lw20",    1'b0, 2'b10, 1'b0, 14'h0020, 32'h0, 32'h00000000, 1'b0);
    req("lw10e",   1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, 32'h00000000, 1'b0);
    chk("init_hold", {31'd0, init_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
